// File: rtl/io_gpio_irq_ctrl.sv
// Wishbone-slave GPIO and edge-interrupt controller for the 16 user pads.
// Pads io[37:30] map to bits 15:8 and io[7:0] to bits 7:0.
module io_gpio_irq_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [15:0] io_in,
  output logic [15:0] io_out,
  output logic [15:0] io_oeb,
  output logic [2:0]  irq
);

  typedef enum logic [2:0] {
    REG_OUT     = 3'd0,
    REG_OEB     = 3'd1,
    REG_IN      = 3'd2,
    REG_RISE_EN = 3'd3,
    REG_FALL_EN = 3'd4,
    REG_STATUS  = 3'd5,
    REG_RSV6    = 3'd6,
    REG_RSV7    = 3'd7
  } reg_idx_e;

  logic [15:0] out_q;
  logic [15:0] oeb_q;
  logic [15:0] rise_en_q;
  logic [15:0] fall_en_q;
  logic [15:0] status_q;
  logic [15:0] sync_q [SYNC_STAGES];
  logic [15:0] prev_q;

  logic        addr_hit;
  logic        req;
  logic        wr_req;
  reg_idx_e    idx;
  logic [15:0] byte_mask;
  logic [15:0] sync_val;
  logic [15:0] rise;
  logic [15:0] fall;
  logic [15:0] clr;
  logic [15:0] rd_data;
  logic        unused_bits;

  assign addr_hit  = (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign req       = wbs_cyc_i & wbs_stb_i & addr_hit & ~wbs_ack_o;
  assign wr_req    = req & wbs_we_i;
  assign idx       = reg_idx_e'(wbs_adr_i[4:2]);
  assign byte_mask = {{8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign sync_val  = sync_q[SYNC_STAGES-1];
  assign rise      = sync_val & ~prev_q;
  assign fall      = ~sync_val & prev_q;
  assign clr       = (wr_req && idx == REG_STATUS) ? (wbs_dat_i[15:0] & byte_mask) : '0;

  assign io_out = out_q;
  assign io_oeb = oeb_q;
  assign irq    = {|status_q, |status_q[15:8], |status_q[7:0]};

  assign unused_bits = &{1'b0, wbs_sel_i[3:2], wbs_adr_i[1:0], wbs_dat_i[31:16]};

  // Read-data mux over the register map; reserved slots read zero.
  always_comb begin
    rd_data = '0;
    case (idx)
      REG_OUT:     rd_data = out_q;
      REG_OEB:     rd_data = oeb_q;
      REG_IN:      rd_data = sync_val;
      REG_RISE_EN: rd_data = rise_en_q;
      REG_FALL_EN: rd_data = fall_en_q;
      REG_STATUS:  rd_data = status_q;
      default:     rd_data = '0;
    endcase
  end

  // Pad input synchronizer chain followed by the edge-detect history flop.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= io_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_val;
    end
  end

  // Single-cycle ack with read data registered alongside it.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else if (req) begin
      wbs_ack_o <= 1'b1;
      wbs_dat_o <= {16'h0000, rd_data};
    end else begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end
  end

  // Byte-masked writes to the RW control registers, on the acking edge.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      out_q     <= '0;
      oeb_q     <= '1;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else if (wr_req) begin
      case (idx)
        REG_OUT:     out_q     <= (out_q & ~byte_mask) | (wbs_dat_i[15:0] & byte_mask);
        REG_OEB:     oeb_q     <= (oeb_q & ~byte_mask) | (wbs_dat_i[15:0] & byte_mask);
        REG_RISE_EN: rise_en_q <= (rise_en_q & ~byte_mask) | (wbs_dat_i[15:0] & byte_mask);
        REG_FALL_EN: fall_en_q <= (fall_en_q & ~byte_mask) | (wbs_dat_i[15:0] & byte_mask);
        default: ;
      endcase
    end
  end

  // Sticky status: set terms are OR-ed after the clear so a same-cycle set wins.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      status_q <= '0;
    end else begin
      status_q <= (status_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);
    end
  end

endmodule

// File: tb/tb_io_gpio_irq_ctrl.sv
// Directed bench for io_gpio_irq_ctrl: register map, byte selects, edge interrupts,
// W1C collision, address filtering and reset during an access.
module tb_io_gpio_irq_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        wb_clk_i;
  logic        wb_rst_n;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [15:0] io_in;
  logic [15:0] io_out;
  logic [15:0] io_oeb;
  logic [2:0]  irq;

  int total;
  int bad;

  io_gpio_irq_ctrl #(.BASE_ADDR(BASE), .SYNC_STAGES(2)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_n (wb_rst_n),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_stb_i(wbs_stb_i),
    .wbs_we_i (wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .irq      (irq)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // Bus transfer starting at a negedge; returns at the negedge where ack is seen.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] wdat, output logic [31:0] rdat, output int lat);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = wdat;
    lat = -1; rdat = '0;
    for (int i = 1; i <= 8 && lat < 0; i++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) begin
        lat  = i;
        rdat = wbs_dat_o;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL ack_timeout adr=%h got=no-ack want=ack", adr);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] exp;
    int lat;
    wb_rst_n = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_n = 1'b1;
    total++; if (io_out !== 16'h0000) begin bad++; $display("FAIL rst_io_out got=%h want=0000", io_out); end
    total++; if (io_oeb !== 16'hFFFF) begin bad++; $display("FAIL rst_io_oeb got=%h want=ffff", io_oeb); end
    total++; if (irq !== 3'b000) begin bad++; $display("FAIL rst_irq got=%b want=000", irq); end
    total++; if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0) begin
      bad++; $display("FAIL rst_bus got=%b/%h want=0/0", wbs_ack_o, wbs_dat_o); end
    for (int i = 0; i < 8; i++) begin
      exp = (i == 1) ? 32'h0000_FFFF : 32'h0;
      wb_xfer(1'b0, BASE + 32'(i * 4), 4'hF, 32'h0, rd, lat);
      total++; if (rd !== exp) begin bad++; $display("FAIL rst_read idx=%0d got=%h want=%h", i, rd, exp); end
      total++; if (lat !== 1) begin bad++; $display("FAIL ack_latency idx=%0d got=%0d want=1", i, lat); end
      @(negedge wb_clk_i);
      total++; if (wbs_ack_o !== 1'b0) begin bad++; $display("FAIL ack_width idx=%0d got=1 want=0", i); end
    end
  endtask

  task automatic test_output_drive();
    logic [31:0] rd;
    int lat;
    wb_xfer(1'b1, BASE + 32'h00, 4'b0001, 32'h0000_A5C3, rd, lat);
    total++; if (io_out !== 16'h00C3) begin bad++; $display("FAIL out_sel0 got=%h want=00c3", io_out); end
    wb_xfer(1'b0, BASE + 32'h00, 4'hF, 32'h0, rd, lat);
    total++; if (rd !== 32'h0000_00C3) begin bad++; $display("FAIL out_read got=%h want=000000c3", rd); end
    wb_xfer(1'b1, BASE + 32'h04, 4'b0011, 32'h0, rd, lat);
    total++; if (io_oeb !== 16'h0000) begin bad++; $display("FAIL oeb_write got=%h want=0000", io_oeb); end
  endtask

  task automatic test_rise_irq();
    logic [31:0] rd;
    int lat;
    wb_xfer(1'b1, BASE + 32'h0C, 4'b0011, 32'h0000_0100, rd, lat);
    io_in[8] = 1'b1;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    total++; if (irq !== 3'b000) begin bad++; $display("FAIL rise_early got=%b want=000", irq); end
    @(negedge wb_clk_i);
    total++; if (irq !== 3'b110) begin bad++; $display("FAIL rise_irq got=%b want=110", irq); end
    wb_xfer(1'b0, BASE + 32'h14, 4'hF, 32'h0, rd, lat);
    total++; if (rd !== 32'h0000_0100) begin bad++; $display("FAIL rise_status got=%h want=00000100", rd); end
    wb_xfer(1'b0, BASE + 32'h08, 4'hF, 32'h0, rd, lat);
    total++; if (rd !== 32'h0000_0100) begin bad++; $display("FAIL in_read got=%h want=00000100", rd); end
    wb_xfer(1'b1, BASE + 32'h14, 4'b0011, 32'h0000_0100, rd, lat);
    total++; if (irq !== 3'b000) begin bad++; $display("FAIL rise_clear got=%b want=000", irq); end
  endtask

  task automatic test_fall_irq();
    logic [31:0] rd;
    int lat;
    wb_xfer(1'b1, BASE + 32'h10, 4'b0011, 32'h0000_0001, rd, lat);
    wb_xfer(1'b1, BASE + 32'h0C, 4'b0011, 32'h0000_0000, rd, lat);
    io_in[0] = 1'b1;
    repeat (4) @(negedge wb_clk_i);
    total++; if (irq !== 3'b000) begin bad++; $display("FAIL fall_on_rise got=%b want=000", irq); end
    io_in[0] = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    total++; if (irq !== 3'b101) begin bad++; $display("FAIL fall_irq got=%b want=101", irq); end
    wb_xfer(1'b0, BASE + 32'h14, 4'hF, 32'h0, rd, lat);
    total++; if (rd !== 32'h0000_0001) begin bad++; $display("FAIL fall_status got=%h want=00000001", rd); end
    wb_xfer(1'b1, BASE + 32'h14, 4'b0011, 32'h0000_FFFF, rd, lat);
    wb_xfer(1'b1, BASE + 32'h10, 4'b0011, 32'h0000_0000, rd, lat);
    total++; if (irq !== 3'b000) begin bad++; $display("FAIL fall_clear got=%b want=000", irq); end
  endtask

  task automatic test_set_clear_collision();
    logic [31:0] rd;
    int lat;
    wb_xfer(1'b1, BASE + 32'h0C, 4'b0011, 32'h0000_0008, rd, lat);
    io_in[3] = 1'b1;
    // rise on bit 3 is present during the second following cycle, same edge as the W1C ack
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_xfer(1'b1, BASE + 32'h14, 4'b0011, 32'h0000_0008, rd, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL collide_lat got=%0d want=1", lat); end
    wb_xfer(1'b0, BASE + 32'h14, 4'hF, 32'h0, rd, lat);
    total++; if (rd !== 32'h0000_0008) begin bad++; $display("FAIL collide_status got=%h want=00000008", rd); end
    wb_xfer(1'b1, BASE + 32'h0C, 4'b0011, 32'h0000_0000, rd, lat);
    total++; if (irq !== 3'b101) begin bad++; $display("FAIL disable_keeps got=%b want=101", irq); end
  endtask

  task automatic test_addr_and_reset();
    int acks;
    acks = 0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_sel_i = 4'hF; wbs_adr_i = BASE + 32'h40; wbs_dat_i = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) acks++;
    end
    total++; if (acks !== 0) begin bad++; $display("FAIL addr_filter got=%0d acks want=0", acks); end
    wbs_adr_i = BASE + 32'h00; wbs_we_i = 1'b1; wbs_sel_i = 4'b0011; wbs_dat_i = 32'h0000_FFFF;
    wb_rst_n = 1'b0;
    @(negedge wb_clk_i);
    total++; if (wbs_ack_o !== 1'b0) begin bad++; $display("FAIL rst_mid_ack got=1 want=0"); end
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wb_rst_n = 1'b1;
    @(negedge wb_clk_i);
    total++; if (wbs_ack_o !== 1'b0) begin bad++; $display("FAIL rst_mid_ack2 got=1 want=0"); end
    total++; if (io_out !== 16'h0000 || io_oeb !== 16'hFFFF) begin
      bad++; $display("FAIL rst_mid_regs got=%h/%h want=0000/ffff", io_out, io_oeb); end
    total++; if (irq !== 3'b000) begin bad++; $display("FAIL rst_mid_irq got=%b want=000", irq); end
  endtask

  initial begin
    total = 0; bad = 0;
    wb_rst_n = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0; io_in = '0;
    @(negedge wb_clk_i);
    test_reset();
    test_output_drive();
    test_rise_irq();
    test_fall_irq();
    test_set_clear_collision();
    test_addr_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
